// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/exec/mem/wb,
// drives datapath enables and mux selects, and traps on illegal classes or memory timeouts.
module rv32_mc_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [9:0] i_dec_flags,
   input  logic       i_br_taken,
   input  logic       i_imem_ready,
   input  logic       i_dmem_ready,
   output logic       o_imem_req,
   output logic       o_ir_we,
   output logic       o_pc_we,
   output logic [1:0] o_pc_src,
   output logic       o_dmem_req,
   output logic       o_dmem_we,
   output logic       o_rf_we,
   output logic [1:0] o_wb_sel,
   output logic       o_instret,
   output logic       o_fault,
   output logic [1:0] o_fault_cause,
   output logic [2:0] o_state
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] C_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   localparam int B_R     = 0;
   localparam int B_LOAD  = 1;
   localparam int B_I     = 2;
   localparam int B_JALR  = 3;
   localparam int B_S     = 4;
   localparam int B_SB    = 5;
   localparam int B_U     = 6;
   localparam int B_JAL   = 7;
   localparam int B_AUIPC = 8;
   localparam int B_CSR   = 9;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [9:0]      r_cls;
   logic [CW-1:0]   r_cnt;
   logic            r_fault;
   logic [1:0]      r_cause;
   logic [1:0]      w_cause;
   logic            w_legal;
   logic            w_onehot;
   logic            w_wait;
   logic            w_expire;
   logic            w_to_wb;

   // auipc arrives from the decoder as the U bit plus its own bit.
   assign w_onehot = (i_dec_flags != 10'd0) && ((i_dec_flags & (i_dec_flags - 10'd1)) == 10'd0);
   assign w_legal  = w_onehot || (i_dec_flags == 10'h140);
   assign w_to_wb  = r_cls[B_R] | r_cls[B_I] | r_cls[B_U] | r_cls[B_AUIPC] |
                     r_cls[B_CSR] | r_cls[B_JAL] | r_cls[B_JALR];
   assign w_wait   = ((r_state == S_FETCH) && !i_imem_ready) ||
                     ((r_state == S_MEM) && !i_dmem_ready);
   assign w_expire = (MEM_TIMEOUT != 0) && (r_cnt == C_LAST);

   always_comb begin
      w_next      = r_state;
      w_cause     = r_cause;
      o_imem_req  = 1'b0;
      o_ir_we     = 1'b0;
      o_pc_we     = 1'b0;
      o_pc_src    = 2'd0;
      o_dmem_req  = 1'b0;
      o_dmem_we   = 1'b0;
      o_rf_we     = 1'b0;
      o_wb_sel    = 2'd0;
      o_instret   = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_ready) begin
               o_ir_we = 1'b1;
               w_next  = S_DECODE;
            end else if (w_expire) begin
               w_next  = S_TRAP;
               w_cause = 2'd1;
            end
         end
         S_DECODE: begin
            if (w_legal) begin
               w_next = S_EXEC;
            end else begin
               w_next  = S_TRAP;
               w_cause = 2'd0;
            end
         end
         S_EXEC: begin
            if (r_cls[B_SB]) begin
               o_pc_we   = 1'b1;
               o_pc_src  = i_br_taken ? 2'd1 : 2'd0;
               o_instret = 1'b1;
               w_next    = S_FETCH;
            end else if (r_cls[B_LOAD] || r_cls[B_S]) begin
               w_next = S_MEM;
            end else if (w_to_wb) begin
               w_next = S_WB;
            end else begin
               w_next  = S_TRAP;
               w_cause = 2'd0;
            end
         end
         S_MEM: begin
            o_dmem_req = 1'b1;
            o_dmem_we  = r_cls[B_S];
            if (i_dmem_ready) begin
               if (r_cls[B_S]) begin
                  o_pc_we   = 1'b1;
                  o_instret = 1'b1;
                  w_next    = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end else if (w_expire) begin
               w_next  = S_TRAP;
               w_cause = 2'd2;
            end
         end
         S_WB: begin
            o_rf_we   = 1'b1;
            o_pc_we   = 1'b1;
            o_instret = 1'b1;
            if (r_cls[B_LOAD])
               o_wb_sel = 2'd1;
            else if (r_cls[B_JAL] || r_cls[B_JALR])
               o_wb_sel = 2'd2;
            else if (r_cls[B_CSR])
               o_wb_sel = 2'd3;
            o_pc_src = r_cls[B_JAL] ? 2'd1 : (r_cls[B_JALR] ? 2'd2 : 2'd0);
            w_next   = S_FETCH;
         end
         S_TRAP: begin
            w_next = S_TRAP;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
      // A reset cycle must not commit anything, even with ready already high.
      if (i_rst) begin
         o_imem_req = 1'b0;
         o_ir_we    = 1'b0;
         o_pc_we    = 1'b0;
         o_pc_src   = 2'd0;
         o_dmem_req = 1'b0;
         o_dmem_we  = 1'b0;
         o_rf_we    = 1'b0;
         o_wb_sel   = 2'd0;
         o_instret  = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_FETCH;
         r_cls   <= '0;
         r_cnt   <= '0;
         r_fault <= 1'b0;
         r_cause <= 2'd0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_DECODE) && w_legal)
            r_cls <= i_dec_flags;
         if (w_next != r_state)
            r_cnt <= '0;
         else if (w_wait && (MEM_TIMEOUT != 0))
            r_cnt <= r_cnt + 1'b1;
         if ((w_next == S_TRAP) && (r_state != S_TRAP)) begin
            r_fault <= 1'b1;
            r_cause <= w_cause;
         end
      end
   end

   assign o_fault       = r_fault;
   assign o_fault_cause = r_cause;
   assign o_state       = r_state;

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Bench for rv32_mc_ctrl: instruction-level reference model checked every cycle,
// plus directed instructions with hand-computed latencies, traces and trap causes.
module tb_rv32_mc_ctrl;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] flags = 10'd0;
   logic       br = 1'b0;
   logic       imem_ready = 1'b0;
   logic       dmem_ready = 1'b0;
   logic       imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we, instret, fault;
   logic [1:0] pc_src, wb_sel, fault_cause;
   logic [2:0] state;

   int  vectors = 0;
   int  errors = 0;
   bit  chk = 1'b0;
   int  idly = 0;
   int  ddly = 0;
   int  i_n = 0;
   int  d_n = 0;
   int  n_ret = 0;

   // reference model: phase names follow the instruction's life, not the RTL encoding
   int         m_phase = 0;
   logic [9:0] m_cls = 10'd0;
   int         m_reqcyc = 1;
   bit         m_fault = 1'b0;
   int         m_cause = 0;

   always #5 clk = ~clk;

   rv32_mc_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_dec_flags(flags), .i_br_taken(br),
      .i_imem_ready(imem_ready), .i_dmem_ready(dmem_ready),
      .o_imem_req(imem_req), .o_ir_we(ir_we), .o_pc_we(pc_we), .o_pc_src(pc_src),
      .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_rf_we(rf_we), .o_wb_sel(wb_sel),
      .o_instret(instret), .o_fault(fault), .o_fault_cause(fault_cause), .o_state(state)
   );

   // memory responders: ready after idly/ddly waiting cycles of the fetch/mem phase
   always @(posedge clk) begin
      #2;
      if (state == 3'd0) i_n = i_n + 1; else i_n = 0;
      if (state == 3'd3) d_n = d_n + 1; else d_n = 0;
      imem_ready = (state == 3'd0) && (i_n > idly);
      dmem_ready = (state == 3'd3) && (d_n > ddly);
   end

   function automatic bit cls_legal(input logic [9:0] f);
      return ($countones(f) == 1) || (f == 10'h140);
   endfunction

   function automatic logic [16:0] model_out();
      logic       e_imr = 0, e_irw = 0, e_pcw = 0, e_dr = 0, e_dw = 0, e_rfw = 0, e_ret = 0;
      logic [1:0] e_ps = 0, e_ws = 0;
      bit is_load = (m_cls == 10'h002), is_store = (m_cls == 10'h010);
      bit is_br = (m_cls == 10'h020), is_jal = (m_cls == 10'h080);
      bit is_jalr = (m_cls == 10'h008), is_csr = (m_cls == 10'h200);
      if (!rst) begin
         if (m_phase == 0) begin
            e_imr = 1; e_irw = imem_ready;
         end else if (m_phase == 2 && is_br) begin
            e_pcw = 1; e_ret = 1; e_ps = br ? 2'd1 : 2'd0;
         end else if (m_phase == 3) begin
            e_dr = 1; e_dw = is_store;
            if (is_store && dmem_ready) begin e_pcw = 1; e_ret = 1; end
         end else if (m_phase == 4) begin
            e_rfw = 1; e_pcw = 1; e_ret = 1;
            e_ws = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : (is_csr ? 2'd3 : 2'd0));
            e_ps = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
         end
      end
      return {e_imr, e_irw, e_pcw, e_ps, e_dr, e_dw, e_rfw, e_ws, e_ret,
              m_fault, 2'(m_cause), 3'(m_phase)};
   endfunction

   function automatic void go(input int p);
      m_phase = p;
      m_reqcyc = 1;
   endfunction

   function automatic void trap(input int c);
      m_phase = 5; m_fault = 1; m_cause = c;
   endfunction

   function automatic void model_advance();
      if (rst) begin
         m_phase = 0; m_reqcyc = 1; m_fault = 0; m_cause = 0;
      end else if (m_phase == 0) begin
         if (imem_ready) go(1);
         else if (TO != 0 && m_reqcyc == TO) trap(1);
         else m_reqcyc++;
      end else if (m_phase == 1) begin
         if (cls_legal(flags)) begin m_cls = flags; go(2); end
         else trap(0);
      end else if (m_phase == 2) begin
         if (m_cls == 10'h020) go(0);
         else if (m_cls == 10'h002 || m_cls == 10'h010) go(3);
         else go(4);
      end else if (m_phase == 3) begin
         if (dmem_ready) go((m_cls == 10'h002) ? 4 : 0);
         else if (TO != 0 && m_reqcyc == TO) trap(2);
         else m_reqcyc++;
      end else if (m_phase == 4) begin
         go(0);
      end
   endfunction

   always @(negedge clk) begin
      logic [16:0] e_v, a_v;
      e_v = model_out();
      a_v = {imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, rf_we, wb_sel, instret,
             fault, fault_cause, state};
      if (chk) begin
         vectors++;
         if (a_v !== e_v) begin
            errors++;
            $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, a_v, e_v);
         end
      end
      if (instret === 1'b1) n_ret++;
      model_advance();
   end

   task automatic check(input string nm, input int act, input int req);
      vectors++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic run_instr(input string nm, input logic [9:0] f, input logic b, input int id,
                            input int dd, input int exp_lat, input int exp_rf,
                            output logic [29:0] tr);
      int n = 0;
      int rfc = 0;
      bit done = 0;
      tr = '0;
      flags = f; br = b; idly = id; ddly = dd;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
         tr = {tr[26:0], state};
         if (rf_we === 1'b1) rfc++;
         if (instret === 1'b1) done = 1;
      end
      check({nm, "_latency"}, n, exp_lat);
      check({nm, "_rf_we_count"}, rfc, exp_rf);
      $display("xact %s flags=%h br=%0d latency=%0d", nm, f, b, n);
      @(posedge clk); #1;
   endtask

   task automatic run_trap(input string nm, input logic [9:0] f, input int id, input int dd,
                           input int exp_n, input int exp_cause);
      int n = 0;
      bit seen = 0;
      flags = f; idly = id; ddly = dd;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (state === 3'd5) seen = 1;
      end
      check({nm, "_trap_cycle"}, n, exp_n);
      check({nm, "_fault"}, int'(fault), 1);
      check({nm, "_cause"}, int'(fault_cause), exp_cause);
      repeat (3) @(negedge clk);
      check({nm, "_stays_trap"}, int'(state), 5);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      check({nm, "_reset_state"}, int'(state), 0);
      check({nm, "_reset_fault"}, int'(fault), 0);
      $display("xact %s flags=%h trap_cycle=%0d cause=%0d", nm, f, n, exp_cause);
      rst = 1'b0;
      idly = 0; ddly = 0;
   endtask

   initial begin
      logic [29:0] tr;
      int ret0;
      int n;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("reset_outputs", int'({imem_req, ir_we, pc_we, pc_src, dmem_req, dmem_we, rf_we,
                                  wb_sel, instret, fault, fault_cause, state}), 0);
      chk = 1'b1;
      rst = 1'b0;

      run_instr("r_type", 10'h001, 1'b0, 0, 0, 4, 1, tr);
      check("r_type_states", int'(tr[11:0]), 12'h054);
      run_instr("load_wait3", 10'h002, 1'b0, 0, 3, 8, 1, tr);
      run_instr("branch_taken", 10'h020, 1'b1, 0, 0, 3, 0, tr);
      run_instr("branch_not", 10'h020, 1'b0, 0, 0, 3, 0, tr);
      run_instr("auipc", 10'h140, 1'b0, 0, 0, 4, 1, tr);
      run_instr("store", 10'h010, 1'b0, 0, 0, 4, 0, tr);
      run_instr("jal", 10'h080, 1'b0, 0, 0, 4, 1, tr);
      run_instr("jalr", 10'h008, 1'b0, 0, 0, 4, 1, tr);
      run_instr("csr", 10'h200, 1'b0, 0, 0, 4, 1, tr);
      run_instr("lui", 10'h040, 1'b0, 0, 0, 4, 1, tr);
      run_instr("i_type", 10'h004, 1'b0, 0, 0, 4, 1, tr);
      run_instr("imem_ready_4th", 10'h001, 1'b0, 3, 0, 7, 1, tr);
      run_instr("load_ready_4th", 10'h002, 1'b0, 0, 3, 8, 1, tr);

      run_trap("zero_hot", 10'h000, 0, 0, 3, 0);
      run_trap("multi_hot", 10'h003, 0, 0, 3, 0);
      run_trap("imem_timeout", 10'h001, 100, 0, 5, 1);
      run_trap("dmem_timeout", 10'h002, 0, 100, 8, 2);

      // store interrupted by reset while dmem_ready is already high
      flags = 10'h010; idly = 0; ddly = 1;
      n = 0;
      while (state !== 3'd3 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("store_reach_mem", int'(state), 3);
      ret0 = n_ret;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("store_rst_pc_we", int'(pc_we), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("store_rst_state", int'(state), 0);
      check("store_rst_dmem_req", int'(dmem_req), 0);
      check("store_rst_no_retire", n_ret, ret0);
      $display("xact store_reset flags=%h retired_during=%0d", flags, n_ret - ret0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
